// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the iterative comparator.
package cmp_pkg;

    // Comparator FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Registered compare result; exactly one bit is set after a completed compare.
    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } cmp_result_t;

    // Number of chunks an operand splits into.
    function automatic int calc_n(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index width: clog2 of the chunk count, never below one bit.
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Default geometry (32-bit operands, 8-bit chunks).
    localparam int CMP_WIDTH_DEF = 32;
    localparam int CMP_CHUNK_DEF = 8;
    localparam int CMP_N_DEF     = calc_n(CMP_WIDTH_DEF, CMP_CHUNK_DEF);
    localparam int CMP_IDX_W_DEF = calc_idx_w(CMP_N_DEF);

endpackage

// File: rtl/cmp_chunk.sv
// Combinational compare of two CHUNK-bit slices. For the most significant
// chunk of a signed compare the MSBs are inverted, which maps two's-complement
// order onto unsigned order. Equality never depends on the sign handling.
module cmp_chunk
    import cmp_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             is_signed_top,
    output logic             ch_eq,
    output logic             ch_lt
);

    logic [CHUNK-1:0] a_adj;
    logic [CHUNK-1:0] b_adj;

    // Apply the sign correction, then do a plain unsigned compare.
    always_comb begin
        a_adj = a;
        b_adj = b;
        if (is_signed_top) begin
            a_adj[CHUNK-1] = ~a[CHUNK-1];
            b_adj[CHUNK-1] = ~b[CHUNK-1];
        end
        ch_eq = (a == b);
        ch_lt = (a_adj < b_adj);
    end

endmodule

// File: rtl/cmp_iter.sv
// Iterative magnitude/equality comparator: scans the operands CHUNK bits per
// cycle from the most significant chunk down.
//
// Build option CMP_ITER_EARLY_EXIT_EN: when defined, RUN stops on the first
// differing chunk (data-dependent latency). When undefined, all N chunks are
// always examined and done arrives in cycle N+1 (constant time). Results are
// identical in both builds.
//
// Handshake: start is sampled only in IDLE (busy=0); the accepting edge
// latches x, y, signed_mode and clears eq/lt/gt. busy is high in RUN and DONE,
// during which start is ignored. done is a one-cycle pulse in DONE; eq/lt/gt
// are valid from that cycle and hold until the next start is accepted.
// State is held in state_q (cmp_state_t) for observation.
module cmp_iter
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int N     = calc_n(WIDTH, CHUNK);
    localparam int IDX_W = calc_idx_w(N);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;

    cmp_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             signed_q, signed_d;
    cmp_result_t      res_q, res_d;

`ifndef CMP_ITER_EARLY_EXIT_EN
    // Remembers the most significant differing chunk while the scan continues.
    logic found_q, found_d;
    logic pend_lt_q, pend_lt_d;
`endif

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic             top_signed;
    logic             ch_eq;
    logic             ch_lt;

    // Select the chunk addressed by idx from the latched operands.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl = opa_q[i*CHUNK +: CHUNK];
                b_sl = opb_q[i*CHUNK +: CHUNK];
            end
        end
        top_signed = signed_q && (idx_q == IDX_TOP);
    end

    cmp_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a            (a_sl),
        .b            (b_sl),
        .is_signed_top(top_signed),
        .ch_eq        (ch_eq),
        .ch_lt        (ch_lt)
    );

    // Next-state, datapath and result update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        signed_d = signed_q;
        res_d    = res_q;
`ifndef CMP_ITER_EARLY_EXIT_EN
        found_d   = found_q;
        pend_lt_d = pend_lt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d    = x;
                    opb_d    = y;
                    signed_d = signed_mode;
                    idx_d    = IDX_TOP;
                    res_d    = '0;
                    state_d  = RUN;
`ifndef CMP_ITER_EARLY_EXIT_EN
                    found_d   = 1'b0;
                    pend_lt_d = 1'b0;
`endif
                end
            end
            RUN: begin
`ifdef CMP_ITER_EARLY_EXIT_EN
                if (!ch_eq) begin
                    res_d.eq = 1'b0;
                    res_d.lt = ch_lt;
                    res_d.gt = ~ch_lt;
                    state_d  = DONE;
                end else if (idx_q == IDX_ZERO) begin
                    res_d.eq = 1'b1;
                    res_d.lt = 1'b0;
                    res_d.gt = 1'b0;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`else
                if (!found_q && !ch_eq) begin
                    found_d   = 1'b1;
                    pend_lt_d = ch_lt;
                end
                if (idx_q == IDX_ZERO) begin
                    state_d = DONE;
                    if (found_q) begin
                        res_d.eq = 1'b0;
                        res_d.lt = pend_lt_q;
                        res_d.gt = ~pend_lt_q;
                    end else if (!ch_eq) begin
                        res_d.eq = 1'b0;
                        res_d.lt = ch_lt;
                        res_d.gt = ~ch_lt;
                    end else begin
                        res_d.eq = 1'b1;
                        res_d.lt = 1'b0;
                        res_d.gt = 1'b0;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            signed_q <= 1'b0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            signed_q <= signed_d;
            res_q    <= res_d;
        end
    end

`ifndef CMP_ITER_EARLY_EXIT_EN
    // Pending-result registers for the constant-time scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            found_q   <= 1'b0;
            pend_lt_q <= 1'b0;
        end else begin
            found_q   <= found_d;
            pend_lt_q <= pend_lt_d;
        end
    end
`endif

    // Outputs are decoded straight from registers.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        eq   = res_q.eq;
        lt   = res_q.lt;
        gt   = res_q.gt;
    end

endmodule

// File: tb/tb_cmp_iter.sv
// Self-checking bench for cmp_iter (WIDTH=32, CHUNK=8).
module tb_cmp_iter;

    localparam int W = 32;
    localparam int C = 8;
    localparam int NCH = W / C;
`ifdef CMP_ITER_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic         eq;
    logic         lt;
    logic         gt;

    int n_cmp  = 0;
    int n_fail = 0;

    cmp_iter #(.WIDTH(W), .CHUNK(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_mode(signed_mode),
        .x          (x),
        .y          (y),
        .busy       (busy),
        .done       (done),
        .eq         (eq),
        .lt         (lt),
        .gt         (gt)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         e_eq;
        logic         e_lt;
        logic         e_gt;
        int           done_early;
        int           done_full;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: ordering from plain integer compares.
    function automatic logic [2:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic l;
        l = s ? ($signed(a) < $signed(b)) : (a < b);
        if (a == b) return 3'b100;
        return l ? 3'b010 : 3'b001;
    endfunction

    // Reference: cycle in which done is expected.
    function automatic int model_done(input logic [W-1:0] a, input logic [W-1:0] b);
        if (!EE) return NCH + 1;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (a[i*C +: C] != b[i*C +: C]) return (NCH - i) + 1;
        end
        return NCH + 1;
    endfunction

    // Driver: called at a negedge in IDLE; leaves at the negedge of the first
    // IDLE cycle after done, so consecutive calls are back-to-back.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [2:0] exp_r, input int exp_done, input string tag);
        int  c;
        bit  seen;
        x = a;
        y = b;
        signed_mode = s;
        start = 1'b1;
        @(posedge clk);
        c = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            check({tag, " busy"}, busy, 1);
            if (c == 1) check({tag, " cleared"}, {eq, lt, gt}, 3'b000);
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, seen, 1);
        check({tag, " done_cycle"}, c, exp_done);
        check({tag, " result"}, {eq, lt, gt}, exp_r);
        @(negedge clk);
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " idle_done"}, done, 0);
        check({tag, " held"}, {eq, lt, gt}, exp_r);
    endtask

    initial begin
        int          c;
        bit          seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic        rs;
        logic [W-1:0] mask;

        // Reset.
        rst_n = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        x = '0;
        y = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", {busy, done, eq, lt, gt}, 5'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table, applied back to back.
        vecs.push_back('{32'h12345678, 32'h12345678, 1'b0, 1, 0, 0, 5, 5});
        vecs.push_back('{32'h80000000, 32'h00000001, 1'b0, 0, 0, 1, 2, 5});
        vecs.push_back('{32'h80000000, 32'h00000001, 1'b1, 0, 1, 0, 2, 5});
        vecs.push_back('{32'h12345600, 32'h12345601, 1'b0, 0, 1, 0, 5, 5});
        vecs.push_back('{32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 0, 1, 0, 2, 5});
        vecs.push_back('{32'hFFFFFFFF, 32'h7FFFFFFF, 1'b0, 0, 0, 1, 2, 5});
        vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 1, 0, 0, 5, 5});
        vecs.push_back('{32'h7FFFFFFF, 32'h80000000, 1'b1, 0, 0, 1, 2, 5});
        vecs.push_back('{32'h1234FF00, 32'h12340100, 1'b1, 0, 0, 1, 4, 5});
        vecs.push_back('{32'h80000001, 32'h80000002, 1'b1, 0, 1, 0, 5, 5});
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s,
                   {vecs[i].e_eq, vecs[i].e_lt, vecs[i].e_gt},
                   EE ? vecs[i].done_early : vecs[i].done_full,
                   $sformatf("vec%0d", i));
        end

        // start during RUN is ignored; operands stay latched.
        x = 32'h12345678;
        y = 32'h12345678;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        c = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            start = 1'b0;
            if (c == 2) begin
                start = 1'b1;
                x = 32'h00000000;
                y = 32'hFFFFFFFF;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("ignored_start done_cycle", c, 5);
        check("ignored_start result", {eq, lt, gt}, 3'b100);
        @(negedge clk);
        check("ignored_start idle", busy, 0);

        // Reset in cycle 2 of a compare aborts it with no done pulse.
        x = 32'hAAAAAAAA;
        y = 32'hAAAAAAAA;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("abort c1 done", done, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort outs", {busy, done, eq, lt, gt}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("abort no_done", seen, 0);
        run_op(32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 3'b010, EE ? 2 : 5, "post_reset");

        // Randomised compares against the reference model.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: mask = 32'h00000000;
                1: mask = 32'hFF000000;
                2: mask = 32'hFFFF0000;
                default: mask = 32'hFFFFFF00;
            endcase
            rb = (ra & mask) | (rb & ~mask);
            if ($urandom_range(0, 9) == 0) rb = ra;
            run_op(ra, rb, rs, model_res(ra, rb, rs), model_done(ra, rb), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
